// File: rtl/board_move_engine_if.sv
// Move/draw handshake and board bus between the move decoder, the engine
// and the number drawer.
interface board_move_engine_if #(
  parameter int CNT_W = 10
);
  logic             load;
  logic [63:0]      board_in;
  logic             move_valid;
  logic [1:0]       move_dir;
  logic             move_ready;
  logic             draw_done;
  logic             draw_req;
  logic [63:0]      numbers;
  logic [3:0]       blank_pos;
  logic [CNT_W-1:0] move_count;
  logic             move_illegal;
  logic             solved;
  logic             board_err;

  modport master (
    output load, board_in, move_valid, move_dir, draw_done,
    input  move_ready, draw_req, numbers, blank_pos, move_count,
           move_illegal, solved, board_err
  );

  modport slave (
    input  load, board_in, move_valid, move_dir, draw_done,
    output move_ready, draw_req, numbers, blank_pos, move_count,
           move_illegal, solved, board_err
  );
endinterface

// File: rtl/board_move_engine.sv
// 4x4 sliding-puzzle game state: validates a loaded board, applies one
// blank move at a time, counts moves and requests a redraw after each change.
module board_move_engine #(
  parameter int MAX_MOVES = 999,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              resetn,
  board_move_engine_if.slave bus
);
  localparam logic [63:0] GOAL = 64'h0FEDCBA987654321;

  typedef enum logic [2:0] {IDLE, SCAN, READY, SWAP, DRAW, ERR} state_t;

  state_t           state, state_nx;
  logic [63:0]      numbers_q;
  logic [3:0]       blank_q;
  logic [CNT_W-1:0] count_q;
  logic             draw_req_q, illegal_q, solved_q, err_q;
  logic [3:0]       scan_k;
  logic [1:0]       zero_cnt;     // saturates at 2: "more than one"
  logic [3:0]       zero_idx;
  logic [3:0]       tgt_q;

  logic [3:0]       scan_nib;
  logic [1:0]       zero_cnt_nx;
  logic [3:0]       zero_idx_nx;
  logic             scan_ok;
  logic             legal;
  logic [3:0]       tgt_nx;
  logic [63:0]      swap_numbers;
  logic [1:0]       row, col;

  assign row = blank_q[3:2];
  assign col = blank_q[1:0];

  assign bus.move_ready   = (state == READY);
  assign bus.draw_req     = draw_req_q;
  assign bus.numbers      = numbers_q;
  assign bus.blank_pos    = blank_q;
  assign bus.move_count   = count_q;
  assign bus.move_illegal = illegal_q;
  assign bus.solved       = solved_q;
  assign bus.board_err    = err_q;

  // Per-cycle scan step: fold cell scan_k into the zero count and index.
  always_comb begin
    scan_nib    = numbers_q[{scan_k, 2'b00} +: 4];
    zero_cnt_nx = zero_cnt;
    zero_idx_nx = zero_idx;
    if (scan_nib == 4'h0) begin
      zero_idx_nx = scan_k;
      if (zero_cnt != 2'd2) zero_cnt_nx = zero_cnt + 2'd1;
    end
    scan_ok = (zero_cnt_nx == 2'd1);
  end

  // Move legality and target cell from the blank's row/column.
  always_comb begin
    legal  = 1'b0;
    tgt_nx = blank_q;
    case (bus.move_dir)
      2'd0: begin legal = (row != 2'd0); tgt_nx = blank_q - 4'd4; end
      2'd1: begin legal = (row != 2'd3); tgt_nx = blank_q + 4'd4; end
      2'd2: begin legal = (col != 2'd0); tgt_nx = blank_q - 4'd1; end
      default: begin legal = (col != 2'd3); tgt_nx = blank_q + 4'd1; end
    endcase
  end

  // Board after sliding the target tile into the blank.
  always_comb begin
    swap_numbers = numbers_q;
    swap_numbers[{blank_q, 2'b00} +: 4] = numbers_q[{tgt_q, 2'b00} +: 4];
    swap_numbers[{tgt_q, 2'b00} +: 4]   = 4'h0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic; load restarts the game from any state.
  always_comb begin
    state_nx = state;
    if (bus.load) state_nx = SCAN;
    else begin
      case (state)
        IDLE:  state_nx = IDLE;
        SCAN:  if (scan_k == 4'd15) state_nx = scan_ok ? DRAW : ERR;
        READY: if (bus.move_valid && legal) state_nx = SWAP;
        SWAP:  state_nx = DRAW;
        DRAW:  if (bus.draw_done) state_nx = READY;
        ERR:   state_nx = ERR;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Board, blank, count and flag registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      numbers_q  <= GOAL;
      blank_q    <= 4'd15;
      count_q    <= '0;
      draw_req_q <= 1'b0;
      illegal_q  <= 1'b0;
      solved_q   <= 1'b1;
      err_q      <= 1'b0;
      scan_k     <= 4'd0;
      zero_cnt   <= 2'd0;
      zero_idx   <= 4'd0;
      tgt_q      <= 4'd0;
    end else begin
      illegal_q <= 1'b0;
      if (bus.load) begin
        numbers_q  <= bus.board_in;
        solved_q   <= (bus.board_in == GOAL);
        count_q    <= '0;
        err_q      <= 1'b0;
        draw_req_q <= 1'b0;
        scan_k     <= 4'd0;
        zero_cnt   <= 2'd0;
        zero_idx   <= 4'd0;
      end else begin
        case (state)
          SCAN: begin
            scan_k   <= scan_k + 4'd1;
            zero_cnt <= zero_cnt_nx;
            zero_idx <= zero_idx_nx;
            if (scan_k == 4'd15) begin
              if (scan_ok) begin
                blank_q    <= zero_idx_nx;
                draw_req_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          READY: begin
            if (bus.move_valid) begin
              if (legal) tgt_q     <= tgt_nx;
              else       illegal_q <= 1'b1;
            end
          end
          SWAP: begin
            numbers_q  <= swap_numbers;
            solved_q   <= (swap_numbers == GOAL);
            blank_q    <= tgt_q;
            draw_req_q <= 1'b1;
            if (count_q != CNT_W'(MAX_MOVES)) count_q <= count_q + CNT_W'(1);
          end
          DRAW: if (bus.draw_done) draw_req_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_board_move_engine.sv
module tb_board_move_engine;
  localparam logic [63:0] GOAL = 64'h0FEDCBA987654321;
  localparam logic [63:0] EZ   = 64'h0BEDFCA987654321;
  localparam logic [63:0] B0   = 64'h1FEDCBA987654320;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  board_move_engine_if #(.CNT_W(10)) bus();

  board_move_engine dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_scan(input logic [63:0] b);
    bus.load = 1'b1; bus.board_in = b;
    step();
    bus.load = 1'b0;
    repeat (16) step();
  endtask

  task automatic finish_draw();
    bus.draw_done = 1'b1;
    step();
    bus.draw_done = 1'b0;
  endtask

  // Full legal move from READY back to READY.
  task automatic mv(input logic [1:0] d);
    bus.move_valid = 1'b1; bus.move_dir = d;
    step();
    bus.move_valid = 1'b0;
    step();
    finish_draw();
  endtask

  initial begin
    bus.load = 1'b0; bus.board_in = '0; bus.move_valid = 1'b0;
    bus.move_dir = 2'd0; bus.draw_done = 1'b0;

    // reset values
    step();
    chk("rst_numbers", bus.numbers, GOAL);
    chk("rst_blank", bus.blank_pos, 15);
    chk("rst_count", bus.move_count, 0);
    chk("rst_draw_req", bus.draw_req, 0);
    chk("rst_ready", bus.move_ready, 0);
    chk("rst_illegal", bus.move_illegal, 0);
    chk("rst_solved", bus.solved, 1);
    chk("rst_err", bus.board_err, 0);
    resetn = 1'b1;
    bus.move_valid = 1'b1;
    step(); step();
    bus.move_valid = 1'b0;
    chk("idle_ignore_move", bus.numbers, GOAL);

    // test 1: EZ board, exactly 16 scan cycles
    bus.load = 1'b1; bus.board_in = EZ;
    step();
    bus.load = 1'b0;
    chk("t1_numbers", bus.numbers, EZ);
    chk("t1_solved", bus.solved, 0);
    repeat (15) step();
    chk("t1_draw_req_at15", bus.draw_req, 0);
    step();
    chk("t1_draw_req_at16", bus.draw_req, 1);
    chk("t1_blank", bus.blank_pos, 15);
    chk("t1_err", bus.board_err, 0);
    chk("t1_ready_in_draw", bus.move_ready, 0);

    // test 2: move up, latency
    finish_draw();
    chk("t2_ready", bus.move_ready, 1);
    chk("t2_draw_clr", bus.draw_req, 0);
    bus.move_valid = 1'b1; bus.move_dir = 2'd0;
    step();
    bus.move_valid = 1'b0;
    chk("t2_T_numbers", bus.numbers, EZ);
    chk("t2_T_draw_req", bus.draw_req, 0);
    step();
    chk("t2_T1_numbers", bus.numbers, 64'hFBED0CA987654321);
    chk("t2_T1_blank", bus.blank_pos, 11);
    chk("t2_T1_count", bus.move_count, 1);
    chk("t2_T1_draw_req", bus.draw_req, 1);
    finish_draw();
    mv(2'd1);
    chk("t2_down_numbers", bus.numbers, EZ);
    chk("t2_down_count", bus.move_count, 2);
    // right at column 3 is illegal
    bus.move_valid = 1'b1; bus.move_dir = 2'd3;
    step();
    bus.move_valid = 1'b0;
    chk("t2_right_illegal", bus.move_illegal, 1);
    chk("t2_right_ready", bus.move_ready, 1);
    chk("t2_right_count", bus.move_count, 2);
    step();
    chk("t2_illegal_pulse", bus.move_illegal, 0);
    bus.draw_done = 1'b1;
    step();
    bus.draw_done = 1'b0;
    chk("t2_stray_done", bus.move_ready, 1);

    // test 3: blank at cell 0, left and up illegal
    load_scan(B0);
    finish_draw();
    chk("t3_blank", bus.blank_pos, 0);
    bus.move_valid = 1'b1; bus.move_dir = 2'd2;
    step();
    chk("t3_left_illegal", bus.move_illegal, 1);
    bus.move_dir = 2'd0;
    step();
    bus.move_valid = 1'b0;
    chk("t3_up_illegal", bus.move_illegal, 1);
    chk("t3_numbers", bus.numbers, B0);
    chk("t3_blank_keep", bus.blank_pos, 0);
    chk("t3_count", bus.move_count, 0);
    chk("t3_ready", bus.move_ready, 1);

    // test 4: right then left returns board; one-move solve
    mv(2'd3);
    chk("t4_r_numbers", bus.numbers, 64'h1FEDCBA987654302);
    chk("t4_r_blank", bus.blank_pos, 1);
    mv(2'd2);
    chk("t4_l_numbers", bus.numbers, B0);
    chk("t4_count", bus.move_count, 2);
    chk("t4_solved0", bus.solved, 0);
    load_scan(64'hF0EDCBA987654321);
    chk("t4_blank14", bus.blank_pos, 14);
    chk("t4_pre_solved", bus.solved, 0);
    finish_draw();
    bus.move_valid = 1'b1; bus.move_dir = 2'd3;
    step();
    bus.move_valid = 1'b0;
    step();
    chk("t4_solved_with_draw", bus.solved, 1);
    chk("t4_solved_draw_req", bus.draw_req, 1);
    chk("t4_goal", bus.numbers, GOAL);
    finish_draw();
    mv(2'd2);
    chk("t4_move_after_solved", bus.move_count, 2);

    // count saturation
    load_scan(B0);
    finish_draw();
    for (int i = 0; i < 500; i++) begin
      mv(2'd3);
      mv(2'd2);
    end
    chk("sat_count", bus.move_count, 999);
    chk("sat_numbers", bus.numbers, B0);

    // test 5: bad boards
    load_scan(64'h1FEDCBA987654300);
    chk("t5_two_err", bus.board_err, 1);
    chk("t5_two_draw_req", bus.draw_req, 0);
    chk("t5_two_ready", bus.move_ready, 0);
    bus.move_valid = 1'b1; bus.move_dir = 2'd3;
    repeat (3) step();
    bus.move_valid = 1'b0;
    chk("t5_ignore_numbers", bus.numbers, 64'h1FEDCBA987654300);
    chk("t5_ignore_count", bus.move_count, 0);
    chk("t5_err_held", bus.board_err, 1);
    bus.load = 1'b1; bus.board_in = 64'h1FEDCBA987654321;
    step();
    bus.load = 1'b0;
    chk("t5_load_clears_err", bus.board_err, 0);
    repeat (16) step();
    chk("t5_none_err", bus.board_err, 1);
    load_scan(EZ);
    chk("t5_valid_err", bus.board_err, 0);
    chk("t5_valid_draw_req", bus.draw_req, 1);

    // test 6: load during DRAW, reset mid-SCAN
    finish_draw();
    bus.move_valid = 1'b1; bus.move_dir = 2'd0;
    step();
    bus.move_valid = 1'b0;
    step();
    chk("t6_in_draw_count", bus.move_count, 1);
    bus.load = 1'b1; bus.board_in = B0;
    step();
    bus.load = 1'b0;
    chk("t6_load_draw_req", bus.draw_req, 0);
    chk("t6_load_count", bus.move_count, 0);
    chk("t6_load_numbers", bus.numbers, B0);
    repeat (5) step();
    resetn = 1'b0; bus.load = 1'b1; bus.board_in = EZ;
    step();
    chk("t6_rst_numbers", bus.numbers, GOAL);
    chk("t6_rst_blank", bus.blank_pos, 15);
    chk("t6_rst_solved", bus.solved, 1);
    chk("t6_rst_ready", bus.move_ready, 0);
    chk("t6_rst_draw_req", bus.draw_req, 0);
    resetn = 1'b1; bus.load = 1'b0;
    repeat (20) step();
    chk("t6_idle_after_rst", bus.draw_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
